// File: rtl/sdcard_clock_monitor.sv
// SD clock feedback monitor: synchronizes the pad clock into PCLK, averages the
// period over WINDOW rising edges, reports the equivalent divider and flags errors.
module sdcard_clock_monitor #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WINDOW       = 8,
  parameter logic [15:0] LOSS_TIMEOUT = 16'd1024
) (
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  input  logic        sd_clk_fb_i,
  input  logic        mon_enable_i,
  input  logic        meas_start_i,
  input  logic [15:0] exp_divider_i,
  input  logic [7:0]  tolerance_i,
  output logic        meas_busy_o,
  output logic        meas_done_o,
  output logic [15:0] meas_period_o,
  output logic [15:0] meas_divider_o,
  output logic        freq_err_o,
  output logic        clk_lost_o,
  output logic [15:0] edge_count_o
);

  localparam int unsigned LOG2W = $clog2(WINDOW);
  localparam int unsigned ACC_W = 16 + LOG2W;
  localparam int unsigned IDX_W = LOG2W + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW);

  typedef enum logic [1:0] {IDLE, ALIGN, MEASURE, EVAL} state_e;

  state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               prev_q;
  logic [15:0]        gap_q, gap_d;
  logic               lost_q, lost_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        per_q, per_d;
  logic [15:0]        div_q, div_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [15:0]        edge_q;

  logic               rise, lost_rise, eval_live;
  logic [15:0]        period_c, half_c, div_c;
  logic [16:0]        diff_c, mag_c;
  logic               err_c;

  assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign lost_rise = lost_d & ~lost_q;

  always_comb begin
    gap_d = gap_q;
    if (rise || !mon_enable_i) gap_d = 16'd0;
    else if (gap_q != 16'hFFFF) gap_d = gap_q + 16'd1;
    // A rise in the threshold cycle clears gap_d, so the edge wins.
    lost_d = mon_enable_i && (gap_d >= LOSS_TIMEOUT);
  end

  // Result arithmetic works straight off the accumulator so EVAL can show it live.
  always_comb begin
    period_c = acc_q[ACC_W-1:LOG2W];
    half_c   = {1'b0, period_c[15:1]};
    div_c    = (half_c == 16'd0) ? 16'd0 : half_c - 16'd1;
    diff_c   = {1'b0, div_c} - {1'b0, exp_divider_i};
    mag_c    = diff_c[16] ? (17'd0 - diff_c) : diff_c;
    err_c    = (mag_c > {9'd0, tolerance_i}) || (&acc_q);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    per_d   = per_q;
    div_d   = div_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (meas_start_i && mon_enable_i) begin
        state_d = ALIGN;
        err_d   = 1'b0;
        acc_d   = '0;
        idx_d   = '0;
      end
      ALIGN: if (rise) state_d = MEASURE;
      MEASURE: begin
        if (acc_q != '1) acc_d = acc_q + 1'b1;
        if (rise) begin
          idx_d = idx_q + 1'b1;
          if (idx_d == IDX_LAST) state_d = EVAL;
        end
      end
      EVAL: begin
        state_d = IDLE;
        per_d   = period_c;
        div_d   = div_c;
        err_d   = err_c;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !mon_enable_i) begin
      state_d = IDLE;
      per_d   = per_q;
      div_d   = div_q;
      err_d   = err_q;
    end else if (state_q != IDLE && lost_rise) begin
      state_d = IDLE;
      per_d   = 16'd0;
      div_d   = 16'd0;
      err_d   = 1'b1;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      gap_q   <= 16'd0;
      lost_q  <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      per_q   <= 16'd0;
      div_q   <= 16'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      edge_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sd_clk_fb_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      gap_q   <= gap_d;
      lost_q  <= lost_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      div_q   <= div_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (rise && mon_enable_i) edge_q <= edge_q + 16'd1;
    end
  end

  assign eval_live      = (state_q == EVAL) && mon_enable_i && !lost_rise;
  assign meas_busy_o    = (state_q != IDLE);
  assign meas_done_o    = eval_live | done_q;
  assign meas_period_o  = eval_live ? period_c : per_q;
  assign meas_divider_o = eval_live ? div_c : div_q;
  assign freq_err_o     = eval_live ? err_c : err_q;
  assign clk_lost_o     = lost_q & mon_enable_i;
  assign edge_count_o   = edge_q;

endmodule

// File: doc/sdcard_clock_monitor.md
# sdcard_clock_monitor

Receive-side checker for the SD card clock. It samples the SD clock fed back from the pad (`sd_clk_fb_i`) in the PCLK domain and measures the average clock period over a window of rising edges. It then converts that period into an equivalent divider value and flags frequency errors or loss of clock. It sits beside the SD clock generator and gives calibration and error logic an independent, measured view of the clock actually on the pin.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops on `sd_clk_fb_i`. Legal values are 2 to 4.
- `WINDOW`, 8: rising-edge periods averaged per measurement. Must be a power of two, from 2 to 64.
- `LOSS_TIMEOUT`, 16'd1024: PCLK cycles with no rising edge before the clock is declared lost.

Ports:
- `PCLK_i`  in  1  APB clock
- `PRESETn_i`  in  1  reset, asynchronous, active-low
- `sd_clk_fb_i`  in  1  SD clock feedback from the pad. Asynchronous to PCLK.
- `mon_enable_i`  in  1  monitor enable. Level-sensitive.
- `meas_start_i`  in  1  single-cycle pulse that starts one measurement
- `exp_divider_i`  in  16  expected generator divider. The expected full period is 2*(exp_divider_i+1) PCLK cycles.
- `tolerance_i`  in  8  allowed |measured − expected| divider difference
- `meas_busy_o`  out  1  measurement in progress
- `meas_done_o`  out  1  single-cycle completion pulse
- `meas_period_o`  out  16  average full period, in PCLK cycles
- `meas_divider_o`  out  16  equivalent divider value
- `freq_err_o`  out  1  last measurement out of tolerance. Sticky until the next start.
- `clk_lost_o`  out  1  no rising edge for `LOSS_TIMEOUT` cycles while enabled
- `edge_count_o`  out  16  free-running count of rising edges seen while enabled. Wraps.

## Operation
- Synchronizer chain of `SYNC_STAGES` flops, reset to 0. A rising edge (`rise`) is the synchronized value being 1 in a cycle where it was 0 in the previous cycle.
- Loss detection:
  - `gap_cnt` (16 b, saturating) is cleared on `rise` or when `mon_enable_i`=0, and increments otherwise.
  - `clk_lost_o` is 1 while `gap_cnt` ≥ `LOSS_TIMEOUT` and `mon_enable_i`=1. It clears on the cycle after the next `rise`.
- States are IDLE, ALIGN, MEASURE, EVAL.
  - IDLE: `meas_busy_o`=0. When `meas_start_i`=1 and `mon_enable_i`=1, go to ALIGN. In the same cycle set busy, clear `freq_err_o`, clear the accumulator (`acc`, 16+log2(`WINDOW`) b) and the edge index.
  - ALIGN: wait for the first `rise`, then go to MEASURE. Nothing is counted before it.
  - MEASURE:
    - `acc` increments every cycle and saturates at all-ones.
    - Each `rise` increments the edge index.
    - When the index reaches `WINDOW`, go to EVAL. `acc` includes the cycle of that final `rise`.
  - EVAL (one cycle):
    - `meas_period_o` = `acc` >> log2(`WINDOW`), saturated to 16'hFFFF.
    - `meas_divider_o` = (`meas_period_o` >> 1) − 1, floored at 0.
    - `freq_err_o` = (|`meas_divider_o` − `exp_divider_i`| > `tolerance_i`) OR `acc` saturated. The difference is computed in 17-bit arithmetic.
    - Pulse `meas_done_o` and return to IDLE.
- Abort rules:
  - `mon_enable_i`=0 in ALIGN, MEASURE or EVAL: go to IDLE next cycle. Busy clears, no done pulse, results hold their old values.
  - `clk_lost_o` rising while busy: go to IDLE. Pulse `meas_done_o`, set `meas_period_o`=0, `meas_divider_o`=0 and `freq_err_o`=1.
- `meas_start_i` while busy is ignored. `meas_start_i` while disabled is ignored.
- `edge_count_o` increments on `rise` when `mon_enable_i`=1.
- `exp_divider_i` and `tolerance_i` are sampled only in EVAL.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and `gap_cnt`, `acc`, the synchronizer and the edge index are all 0.
- Edge detection latency: `rise` asserts `SYNC_STAGES`+1 PCLK cycles after the pin edge, assuming the edge is captured cleanly.
- Start to busy: `meas_busy_o`=1 in the cycle after `meas_start_i`.
- Measurement latency: from the first detected `rise` to `meas_done_o` takes `WINDOW`×period + 1 cycles. Results are valid in the same cycle as `meas_done_o` and held afterwards.
- `meas_busy_o` falls in the cycle after `meas_done_o`. A new `meas_start_i` is accepted in that cycle.
- Fastest measurable clock: divider 0, giving a period of 2 PCLK cycles. Anything faster aliases, and no detection of that is required.
- A `rise` and a loss threshold crossing in the same cycle: the `rise` wins and the clock is not flagged as lost.
- Asynchronous reset mid-measurement: all state clears immediately and no `meas_done_o` pulse is generated.

## Test plan
- Generator driven at divider 3 (8-cycle period), `exp_divider_i`=3, `tolerance_i`=0, `WINDOW`=8, start pulse → `meas_done_o` once, `meas_period_o`=8, `meas_divider_o`=3, `freq_err_o`=0, busy for about 66+`SYNC_STAGES` cycles.
- Divider 9 (period 20), `exp_divider_i`=7, `tolerance_i`=1 → `meas_divider_o`=9, `freq_err_o`=1. Repeat with `tolerance_i`=2 → `freq_err_o`=0.
- Clock stopped low during MEASURE, `LOSS_TIMEOUT`=1024 → `clk_lost_o`=1 exactly 1024 cycles after the last `rise`, `meas_done_o` pulse, period 0, divider 0, `freq_err_o`=1. Restarting the clock clears `clk_lost_o`.
- `mon_enable_i` dropped mid-MEASURE → busy falls the next cycle, no `meas_done_o`, previous results unchanged, `gap_cnt` cleared.
- Second `meas_start_i` while busy, plus a start with enable=0 → both ignored, exactly one `meas_done_o`. Start with period 2 (divider 0) → `meas_period_o`=2, `meas_divider_o`=0.
- Reset asserted mid-measurement → every output is 0 immediately and the FSM is in IDLE. Then 20 rising edges with enable=1 → `edge_count_o`=20.
